// File: rtl/lcd_ctrl.sv
// HD44780-style character LCD bus sequencer fed by the LSU LCD register.
// One write buffers while a transaction runs; busy and sticky drop status are reported.
module lcd_ctrl #(
  parameter int T_AS_CYC   = 2,
  parameter int T_PW_CYC   = 25,
  parameter int T_H_CYC    = 2,
  parameter int T_EXEC_CYC = 2500,
  parameter int T_LONG_CYC = 82000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_io_lcd,
  input  logic        i_lcd_vld,
  output logic        o_busy,
  output logic        o_drop,
  output logic [7:0]  LCD_DATA,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        LCD_EN,
  output logic        LCD_ON,
  output logic        LCD_BLON
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max2(max2(max2(T_AS_CYC, T_PW_CYC), max2(T_H_CYC, T_EXEC_CYC)),
                              T_LONG_CYC);
  localparam int CW = $clog2(T_MAX) + 1;

  localparam logic [CW-1:0] C_AS   = CW'(T_AS_CYC);
  localparam logic [CW-1:0] C_PW   = CW'(T_PW_CYC);
  localparam logic [CW-1:0] C_H    = CW'(T_H_CYC);
  localparam logic [CW-1:0] C_EXEC = CW'(T_EXEC_CYC);
  localparam logic [CW-1:0] C_LONG = CW'(T_LONG_CYC);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC} state_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_word_t;

  state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  lcd_word_t word_q, word_d;
  lcd_word_t pend_q, pend_d;
  logic      pend_vld_q, pend_vld_d;
  logic      drop_q, drop_d;
  logic      on_q, blon_q;

  lcd_word_t in_word;
  logic      last;
  logic      is_long;
  logic      unused_io_bits;

  assign in_word        = {i_io_lcd[10], i_io_lcd[7:0]};
  assign unused_io_bits = ^{i_io_lcd[29:11], i_io_lcd[9:8]};
  assign last           = (cnt_q == C_ONE);
  // Clear/home are the slow commands on the controller.
  assign is_long = !word_q.rs && (word_q.data inside {8'h01, 8'h02, 8'h03});

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    drop_d     = drop_q;

    unique case (state_q)
      IDLE: if (i_lcd_vld) begin
        state_d = SETUP;
        cnt_d   = C_AS;
        word_d  = in_word;
      end
      SETUP: if (last) begin state_d = PULSE; cnt_d = C_PW; end
             else cnt_d = cnt_q - C_ONE;
      PULSE: if (last) begin state_d = HOLD; cnt_d = C_H; end
             else cnt_d = cnt_q - C_ONE;
      HOLD:  if (last) begin state_d = EXEC; cnt_d = is_long ? C_LONG : C_EXEC; end
             else cnt_d = cnt_q - C_ONE;
      EXEC: begin
        if (!last) begin
          cnt_d = cnt_q - C_ONE;
        end else if (pend_vld_q) begin
          // Pending goes out; a coinciding strobe refills the slot, so nothing is lost.
          state_d = SETUP;
          cnt_d   = C_AS;
          word_d  = pend_q;
          if (i_lcd_vld) pend_d = in_word;
          else           pend_vld_d = 1'b0;
        end else if (i_lcd_vld) begin
          state_d = SETUP;
          cnt_d   = C_AS;
          word_d  = in_word;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (i_lcd_vld && (state_q != IDLE) && !((state_q == EXEC) && last)) begin
      if (!pend_vld_q) begin
        pend_vld_d = 1'b1;
        pend_d     = in_word;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      word_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      drop_q     <= 1'b0;
      on_q       <= 1'b0;
      blon_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      drop_q     <= drop_d;
      on_q       <= i_io_lcd[31];
      blon_q     <= i_io_lcd[30];
    end
  end

  assign LCD_DATA = word_q.data;
  assign LCD_RS   = word_q.rs;
  assign LCD_RW   = 1'b0;
  assign LCD_EN   = (state_q == PULSE);
  assign LCD_ON   = on_q;
  assign LCD_BLON = blon_q;
  assign o_busy   = (state_q != IDLE) | pend_vld_q;
  assign o_drop   = drop_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: stimulus queues expected EN pulses, a monitor
// checks each pulse's RS/DATA, width and the gap to the next pulse or to idle.
`timescale 1ns/1ps
module tb_lcd_ctrl;

  localparam int T_AS   = 2;
  localparam int T_PW   = 25;
  localparam int T_H    = 2;
  localparam int T_EXEC = 100;
  localparam int T_LONG = 400;
  localparam int TXN    = T_AS + T_PW + T_H + T_EXEC;   // 129
  localparam int TXL    = T_AS + T_PW + T_H + T_LONG;   // 429
  localparam int GAP_N  = T_H + T_EXEC;                 // HOLD+EXEC, ends in idle
  localparam int GAP_B  = T_H + T_EXEC + T_AS;          // back-to-back to next EN rise
  localparam int GAP_LIMIT = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_io_lcd;
  logic        i_lcd_vld;
  logic        o_busy, o_drop;
  logic [7:0]  LCD_DATA;
  logic        LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON;

  always #5 clk = ~clk;

  lcd_ctrl #(
    .T_AS_CYC(T_AS), .T_PW_CYC(T_PW), .T_H_CYC(T_H),
    .T_EXEC_CYC(T_EXEC), .T_LONG_CYC(T_LONG)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_io_lcd(i_io_lcd), .i_lcd_vld(i_lcd_vld),
    .o_busy(o_busy), .o_drop(o_drop), .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON)
  );

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         pw;
    int         gap;
    bit         b2b;
  } exp_t;

  typedef enum int {M_IDLE, M_HIGH, M_GAP} mon_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic push(input logic [31:0] w, input int pw, input int gap, input bit b2b);
    sb.push_back('{rs: w[10], data: w[7:0], pw: pw, gap: gap, b2b: b2b});
  endtask

  // Called at a negedge; the strobe is sampled by the following posedge.
  task automatic strobe(input logic [31:0] w);
    i_io_lcd  = w;
    i_lcd_vld = 1'b1;
    @(negedge clk);
    i_lcd_vld = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (o_busy && n < GAP_LIMIT) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Monitor: decoupled from stimulus, pops one expectation per EN pulse.
  initial begin : monitor
    exp_t cur;
    int   width;
    int   g;
    mon_t mst;
    bit   pulse_start;
    cur   = '{rs: 1'b0, data: 8'h00, pw: 0, gap: 0, b2b: 1'b0};
    width = 0;
    g     = 0;
    mst   = M_IDLE;
    forever begin
      @(negedge clk);
      pulse_start = 1'b0;
      case (mst)
        M_IDLE: if (LCD_EN) pulse_start = 1'b1;
        M_HIGH: begin
          if (LCD_EN) begin
            width++;
            check("en_data_held", {LCD_RS, LCD_DATA}, {cur.rs, cur.data});
          end else begin
            check("en_width", width, cur.pw);
            g   = 0;
            mst = M_GAP;
          end
        end
        M_GAP: g++;
        default: mst = M_IDLE;
      endcase
      if (mst == M_GAP) begin
        if (LCD_EN) begin
          check("gap_b2b", 1, cur.b2b);
          check("gap_len", g, cur.gap);
          pulse_start = 1'b1;
        end else if (!o_busy) begin
          check("gap_b2b", 0, cur.b2b);
          check("gap_len", g, cur.gap);
          mst = M_IDLE;
        end else if (g > GAP_LIMIT) begin
          check("gap_timeout", g, cur.gap);
          mst = M_IDLE;
        end
      end
      if (pulse_start) begin
        if (sb.size() == 0) begin
          check("unexpected_en", 1, 0);
          cur = '{rs: 1'b0, data: 8'h00, pw: 0, gap: 0, b2b: 1'b0};
        end else begin
          cur = sb.pop_front();
          check("en_rs", LCD_RS, cur.rs);
          check("en_data", LCD_DATA, cur.data);
        end
        width = 1;
        mst   = M_HIGH;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int n2;
    rst       = 1'b1;
    i_io_lcd  = '0;
    i_lcd_vld = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_en", LCD_EN, 0);
    check("rst_busy", o_busy, 0);
    check("rst_drop", o_drop, 0);
    check("rst_data", {LCD_RS, LCD_DATA}, 0);
    check("rst_rw", LCD_RW, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single data write: bus update on the capture edge, EN at +2, busy for TXN cycles.
    push(32'h0000_0441, T_PW, GAP_N, 1'b0);
    strobe(32'h0000_0441);
    check("t1_data", LCD_DATA, 8'h41);
    check("t1_rs", LCD_RS, 1);
    check("t1_en_setup", LCD_EN, 0);
    check("t1_busy", o_busy, 1);
    n = 0;
    while (!LCD_EN && n < 10) begin @(negedge clk); n++; end
    check("t1_en_offset", n, T_AS);
    wait_idle(n2);
    check("t1_txn_len", n + n2, TXN);
    check("t1_data_kept", LCD_DATA, 8'h41);

    // Long vs short execution waits, including RS/DATA boundaries.
    push(32'h0000_0001, T_PW, T_H + T_LONG, 1'b0);
    strobe(32'h0000_0001);
    wait_idle(n);
    check("t2_clear_len", n, TXL);
    push(32'h0000_0003, T_PW, T_H + T_LONG, 1'b0);
    strobe(32'h0000_0003);
    wait_idle(n);
    check("t2_0x03_len", n, TXL);
    push(32'h0000_0401, T_PW, GAP_N, 1'b0);
    strobe(32'h0000_0401);
    wait_idle(n);
    check("t2_rs1_0x01_len", n, TXN);
    push(32'h0000_0038, T_PW, GAP_N, 1'b0);
    strobe(32'h0000_0038);
    wait_idle(n);
    check("t2_0x38_len", n, TXN);

    // Strobe on the final EXEC cycle, pending empty.
    push(32'h0000_0438, T_PW, GAP_B, 1'b1);
    push(32'h0000_0439, T_PW, GAP_N, 1'b0);
    strobe(32'h0000_0438);
    repeat (TXN - 1) @(negedge clk);
    strobe(32'h0000_0439);
    check("t4a_direct_data", LCD_DATA, 8'h39);
    wait_idle(n);
    check("t4a_len", n, TXN);
    check("t4a_drop", o_drop, 0);

    // Strobe on the final EXEC cycle, pending full.
    push(32'h0000_0451, T_PW, GAP_B, 1'b1);
    push(32'h0000_0452, T_PW, GAP_B, 1'b1);
    push(32'h0000_0453, T_PW, GAP_N, 1'b0);
    strobe(32'h0000_0451);
    repeat (4) @(negedge clk);
    strobe(32'h0000_0452);
    repeat (TXN - 6) @(negedge clk);
    strobe(32'h0000_0453);
    check("t4b_pend_issued", LCD_DATA, 8'h52);
    check("t4b_busy", o_busy, 1);
    wait_idle(n);
    check("t4b_len", n, 2 * TXN);
    check("t4b_drop", o_drop, 0);

    // ON/BLON follow the word with one cycle of latency, no strobe.
    i_io_lcd = 32'hC000_0000;
    check("t5_on_before_edge", {LCD_ON, LCD_BLON}, 2'b00);
    @(negedge clk);
    check("t5_on_blon", {LCD_ON, LCD_BLON}, 2'b11);
    repeat (5) @(negedge clk);
    check("t5_no_busy", o_busy, 0);
    check("t5_no_en", LCD_EN, 0);

    // Three strobes 5 cycles apart: two issue back-to-back, third dropped.
    push(32'h0000_0441, T_PW, GAP_B, 1'b1);
    push(32'h0000_0442, T_PW, GAP_N, 1'b0);
    strobe(32'h0000_0441);
    repeat (4) @(negedge clk);
    strobe(32'h0000_0442);
    check("t3_drop_before", o_drop, 0);
    repeat (4) @(negedge clk);
    strobe(32'h0000_0443);
    check("t3_drop_set", o_drop, 1);
    wait_idle(n);
    check("t3_len", n, 2 * TXN - 10);
    check("t3_drop_sticky", o_drop, 1);

    // Reset in the middle of the EN pulse (EN high for 10 samples before it).
    push(32'h0000_0441, 10, 0, 1'b0);
    strobe(32'h0000_0441);
    repeat (12) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_en", LCD_EN, 0);
    check("t6_data", LCD_DATA, 0);
    check("t6_rs", LCD_RS, 0);
    check("t6_busy", o_busy, 0);
    check("t6_drop", o_drop, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    push(32'h0000_0445, T_PW, GAP_N, 1'b0);
    strobe(32'h0000_0445);
    check("t6_after_data", LCD_DATA, 8'h45);
    wait_idle(n);
    check("t6_after_len", n, TXN);
    check("t6_after_drop", o_drop, 0);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
Downstream consumer of the LSU LCD register. It takes the 32-bit LCD word and its write strobe, and sequences the HD44780-style character LCD bus. The sequence is setup, EN pulse, hold, then command-execution wait. Software therefore never drives EN timing by hand. It sits between the LSU and the DE2 LCD board pins, buffers one pending write, and reports busy and drop status.

Parameters:
T_AS_CYC, 2, cycles RS/DATA are stable before EN rises
T_PW_CYC, 25, cycles EN is held high (500 ns at 50 MHz)
T_H_CYC, 2, cycles RS/DATA are held after EN falls
T_EXEC_CYC, 2500, execution wait for normal commands/data (50 us)
T_LONG_CYC, 82000, execution wait for clear/home (1.64 ms)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-high reset
i_io_lcd  in  32  LCD word from LSU: [31] ON, [30] BLON, [10] RS, [7:0] DATA; other bits ignored
i_lcd_vld  in  1  one-cycle strobe: LSU stored to the LCD register this cycle
o_busy  out  1  transaction in progress or pending entry held
o_drop  out  1  sticky: a write was lost because the pending buffer was full
LCD_DATA  out  8  LCD data bus
LCD_RS  out  1  register select
LCD_RW  out  1  read/write, tied 0 (write-only)
LCD_EN  out  1  enable strobe
LCD_ON  out  1  panel power
LCD_BLON  out  1  backlight

Behaviour:
- Reset (async, i_rst=1): all outputs 0 immediately, FSM to IDLE, pending cleared, counter cleared, o_drop cleared. Applies mid-transaction; EN drops at once.
- LCD_ON and LCD_BLON are registered from i_io_lcd[31] and [30] every cycle (1-cycle latency), independent of the strobe.
- Write capture: at the strobe edge the word {RS=i_io_lcd[10], DATA=i_io_lcd[7:0]} is sampled.
- FSM states: IDLE, SETUP, PULSE, HOLD, EXEC.
- IDLE + i_lcd_vld: next edge enters SETUP; LCD_RS/LCD_DATA update on that same edge; EN=0.
- SETUP lasts T_AS_CYC cycles, then PULSE.
- PULSE lasts T_PW_CYC cycles with EN=1, then HOLD (EN=0).
- HOLD lasts T_H_CYC cycles, then EXEC.
- EXEC lasts T_LONG_CYC cycles if RS=0 and DATA is 0x01, 0x02 or 0x03; otherwise T_EXEC_CYC cycles.
- On leaving EXEC: enter SETUP with the pending entry if one is held (no IDLE cycle), else go to IDLE.
- LCD_RS/LCD_DATA hold their value through the whole transaction and keep the last value in IDLE.
- One shared down-counter, width $clog2(max parameter)+1, is loaded on each state entry; a state ends when the counter reaches 1.
- i_lcd_vld while not IDLE:
  - pending empty: word stored in pending.
  - pending full: word discarded, o_drop set to 1 (sticky until reset).
- Simultaneous events on the final EXEC cycle:
  - pending empty: the new word goes directly to SETUP.
  - pending full: pending goes to SETUP and the new word is written into pending; no drop.
- o_busy = (state != IDLE) | pending_valid. Registered-state derived; it rises the cycle after the accepting strobe.
- Transaction length from SETUP entry to IDLE: T_AS+T_PW+T_H+T_EXEC (or T_LONG) cycles.

Test Plan:
- Reset, then strobe 0x0000_0441 (RS=1, DATA=0x41) -> next edge LCD_DATA=0x41, LCD_RS=1; EN high exactly 25 cycles starting 2 cycles later; o_busy low exactly 2529 cycles after SETUP entry.
- Strobe 0x0000_0001 (clear) -> EXEC lasts 82000 cycles; a 0x0000_0038 write lasts 2500 cycles.
- Strobes 0x441, 0x442, 0x443 spaced 5 cycles apart -> first two produce EN pulses in order (0x41 then 0x42, back-to-back with no IDLE gap); 0x43 dropped; o_drop=1 and stays 1.
- Strobe on the last EXEC cycle with pending empty -> word enters SETUP next edge; no drop. Repeat with pending full -> pending issued, new word buffered; o_drop stays 0.
- i_io_lcd[31:30]=2'b11 with no strobe -> LCD_ON=LCD_BLON=1 one cycle later; no EN pulse.
- Assert i_rst for 1 cycle while in PULSE -> LCD_EN, LCD_DATA, LCD_RS, o_busy, o_drop go to 0 without waiting for a clock edge; FSM to IDLE; next strobe runs a full, correct transaction.
